// File: rtl/load_store_sequencer.sv
// Hardwired T-state control sequencer for the Mini SRC datapath: fetch, ld/ldi/st/nop/halt execute.
// Optional SEQ_TIMEOUT_EN bounds memory waits with a counter and an ERR state.
module load_store_sequencer #(
  parameter int                OPC_W    = 5,
  parameter logic [OPC_W-1:0]  OPC_LD   = 5'b00000,
  parameter logic [OPC_W-1:0]  OPC_LDI  = 5'b00001,
  parameter logic [OPC_W-1:0]  OPC_ST   = 5'b00010,
  parameter logic [OPC_W-1:0]  OPC_HALT = 5'b11011,
  parameter int                WAIT_W   = 4,
  parameter int                TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_done,
  input  logic [OPC_W-1:0] opcode,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             Cout,
  output logic             BAout,
  output logic             Rout,
  output logic             MARIn,
  output logic             PCIn,
  output logic             MDRIn,
  output logic             IRIn,
  output logic             YIn,
  output logic             ZIn,
  output logic             RIn,
  output logic             IncPC,
  output logic             Gra,
  output logic             Grb,
  output logic             add,
  output logic             read,
  output logic             write,
  output logic [3:0]       step,
  output logic             busy,
  output logic             halted,
  output logic             error
);

  // state | meaning
  // IDLE  | waiting for run
  // T0    | PC to MAR, increment PC
  // T1    | instruction read, waits on mem_done
  // T2    | MDR to IR
  // T3    | decode, base register to Y
  // T4    | effective address into Z
  // T5    | ldi writeback, or address to MAR
  // T6    | ld read (waits) / st data to MDR
  // T7    | ld writeback / st write (waits)
  // HALT  | stopped until reset
  // ERR   | memory wait timeout, stopped until reset
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,  S_ERR = 4'd1,
    S_T0   = 4'd7,  S_T1  = 4'd8,  S_T2 = 4'd9,  S_T3 = 4'd10,
    S_T4   = 4'd11, S_T5  = 4'd12, S_T6 = 4'd13, S_T7 = 4'd14,
    S_HALT = 4'd15
  } state_t;

  typedef enum logic [1:0] {K_NONE, K_LD, K_LDI, K_ST} kind_t;

  state_t state;
  kind_t  kind;
  kind_t  op_kind;
  logic   t1_first;

  always_comb begin
    op_kind = K_NONE;
    if (opcode == OPC_LD)       op_kind = K_LD;
    else if (opcode == OPC_LDI) op_kind = K_LDI;
    else if (opcode == OPC_ST)  op_kind = K_ST;
  end

`ifdef SEQ_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_wait;
  assign in_wait = (state == S_T1) || (state == S_T6 && kind == K_LD) ||
                   (state == S_T7 && kind == K_ST);
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_IDLE;
      kind     <= K_NONE;
      t1_first <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      // T1 is only entered from T0, so this marks its first cycle
      t1_first <= (state == S_T0);
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   if (mem_done) state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3: begin
          kind <= op_kind;
          if (opcode == OPC_HALT)     state <= S_HALT;
          else if (op_kind == K_NONE) state <= run ? S_T0 : S_IDLE;
          else                        state <= S_T4;
        end
        S_T4:   state <= S_T5;
        S_T5:   if (kind == K_LDI) state <= run ? S_T0 : S_IDLE;
                else               state <= S_T6;
        S_T6:   if (kind != K_LD || mem_done) state <= S_T7;
        S_T7:   if (kind != K_ST || mem_done) state <= run ? S_T0 : S_IDLE;
        S_HALT, S_ERR: state <= state;
        default: state <= S_IDLE;
      endcase
`ifdef SEQ_TIMEOUT_EN
      // overrides the case above when a wait has run out
      if (in_wait && !mem_done) begin
        if (wait_cnt == TO_LAST) state <= S_ERR;
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
`endif
    end
  end

  always_comb begin
    {PCout, Zlowout, MDRout, Cout, BAout, Rout} = '0;
    {MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn}   = '0;
    {IncPC, Gra, Grb, add, read, write}          = '0;
    busy   = 1'b0;
    halted = 1'b0;
    case (state)
      S_T0: begin
        busy = 1'b1; PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1;
      end
      S_T1: begin
        busy = 1'b1; Zlowout = 1'b1; PCIn = t1_first; read = 1'b1; MDRIn = 1'b1;
      end
      S_T2: begin
        busy = 1'b1; MDRout = 1'b1; IRIn = 1'b1;
      end
      S_T3: begin
        busy = 1'b1;
        if (op_kind != K_NONE) begin
          Grb = 1'b1; BAout = 1'b1; YIn = 1'b1;
        end
      end
      S_T4: begin
        busy = 1'b1; Cout = 1'b1; add = 1'b1; ZIn = 1'b1;
      end
      S_T5: begin
        busy = 1'b1; Zlowout = 1'b1;
        if (kind == K_LDI) begin
          Gra = 1'b1; RIn = 1'b1;
        end else begin
          MARIn = 1'b1;
        end
      end
      S_T6: begin
        busy = 1'b1;
        if (kind == K_LD) begin
          read = 1'b1; MDRIn = 1'b1;
        end else begin
          Gra = 1'b1; Rout = 1'b1; MDRIn = 1'b1;
        end
      end
      S_T7: begin
        busy = 1'b1;
        if (kind == K_LD) begin
          MDRout = 1'b1; Gra = 1'b1; RIn = 1'b1;
        end else begin
          write = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign step = state;
`ifdef SEQ_TIMEOUT_EN
  assign error = (state == S_ERR);
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: builds expected per-cycle step/strobe traces from the instruction
// rules and drives randomized instruction streams and memory latencies. Honours SEQ_TIMEOUT_EN.
module tb_load_store_sequencer;

  logic clk = 1'b0;
  logic clr, run, mem_done;
  logic [4:0] opcode;
  logic PCout, Zlowout, MDRout, Cout, BAout, Rout;
  logic MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn;
  logic IncPC, Gra, Grb, add, read, write;
  logic [3:0] step;
  logic busy, halted, error;

  load_store_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .mem_done(mem_done), .opcode(opcode),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn), .ZIn(ZIn), .RIn(RIn),
    .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .add(add), .read(read), .write(write),
    .step(step), .busy(busy), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  localparam int P_PCOUT = 0,  P_ZLOW = 1,  P_MDROUT = 2, P_COUT = 3,  P_BAOUT = 4,  P_ROUT = 5;
  localparam int P_MARIN = 6,  P_PCIN = 7,  P_MDRIN = 8,  P_IRIN = 9,  P_YIN = 10,  P_ZIN = 11;
  localparam int P_RIN = 12,   P_INCPC = 13, P_GRA = 14,  P_GRB = 15,  P_ADD = 16,  P_READ = 17;
  localparam int P_WRITE = 18, P_BUSY = 19, P_HALTED = 20, P_ERROR = 21;
  localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_NOP = 3, K_HALT = 4;
  localparam int TO_CYCLES = 15;

  logic [21:0] dut_vec;
  assign dut_vec = {error, halted, busy, write, read, add, Grb, Gra, IncPC, RIn, ZIn, YIn, IRIn,
                    MDRIn, PCIn, MARIn, Rout, BAout, Cout, MDRout, Zlowout, PCout};

  int errors = 0;
  int checks = 0;

  logic [25:0] q_exp[$];
  logic [25:0] q_obs[$];
  bit          q_md[$];
  bit          q_run[$];
  logic [4:0]  q_op[$];
  logic [4:0]  b_op;
  bit          b_last;
  int          b_drop, b_c;

  function automatic logic [21:0] m(input int a, input int b = -1, input int c = -1,
                                    input int d = -1, input int e = -1);
    logic [21:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    if (e >= 0) v[e] = 1'b1;
    return v;
  endfunction

  function automatic bit rbit();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] op_for(input int kind);
    logic [4:0] x;
    case (kind)
      K_LD:    return 5'b00000;
      K_LDI:   return 5'b00001;
      K_ST:    return 5'b00010;
      K_HALT:  return 5'b11011;
      default: begin
        x = 5'(($urandom_range(3, 26)));
        return x;
      end
    endcase
  endfunction

  // run stays 1 until cycle b_drop of the final instruction, then 0
  task automatic push(input logic [3:0] s, input logic [21:0] v, input bit md);
    q_exp.push_back({s, v});
    q_md.push_back(md);
    q_run.push_back(!(b_last && b_c >= b_drop));
    q_op.push_back(b_op);
    b_c++;
  endtask

  task automatic begin_stream(input logic [4:0] op);
    b_op = op; b_last = 1'b0; b_c = 0; b_drop = 0;
    push(4'd0, '0, rbit());
  endtask

  task automatic build(input int kind, input logic [4:0] op, input int w1, input int w2,
                       input bit last, input int drop);
    logic [21:0] bz;
    bz = m(P_BUSY);
    b_op = op; b_last = last; b_drop = drop; b_c = 0;
    push(4'd7, bz | m(P_PCOUT, P_MARIN, P_INCPC, P_ZIN), rbit());
    for (int i = 0; i <= w1; i++)
      push(4'd8, bz | m(P_ZLOW, P_READ, P_MDRIN, (i == 0) ? P_PCIN : -1), i == w1);
    push(4'd9, bz | m(P_MDROUT, P_IRIN), rbit());
    if (kind == K_NOP || kind == K_HALT) begin
      push(4'd10, bz, rbit());
      return;
    end
    push(4'd10, bz | m(P_GRB, P_BAOUT, P_YIN), rbit());
    push(4'd11, bz | m(P_COUT, P_ADD, P_ZIN), rbit());
    if (kind == K_LDI) begin
      push(4'd12, bz | m(P_ZLOW, P_GRA, P_RIN), rbit());
      return;
    end
    push(4'd12, bz | m(P_ZLOW, P_MARIN), rbit());
    if (kind == K_LD) begin
      for (int i = 0; i <= w2; i++) push(4'd13, bz | m(P_READ, P_MDRIN), i == w2);
      push(4'd14, bz | m(P_MDROUT, P_GRA, P_RIN), rbit());
    end else begin
      push(4'd13, bz | m(P_GRA, P_ROUT, P_MDRIN), rbit());
      for (int i = 0; i <= w2; i++) push(4'd14, bz | m(P_WRITE), i == w2);
    end
  endtask

  task automatic end_stream();
    b_last = 1'b1; b_drop = 0;
    push(4'd0, '0, rbit());
  endtask

  task automatic run_trace(input int limit);
    int n;
    n = q_exp.size();
    if (limit < n) n = limit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      q_obs.push_back({step, dut_vec});
      mem_done = q_md[i];
      run      = q_run[i];
      opcode   = q_op[i];
    end
  endtask

  task automatic clear_q();
    q_exp.delete(); q_obs.delete(); q_md.delete(); q_run.delete(); q_op.delete();
  endtask

  task automatic apply_clr();
    @(negedge clk);
    #2 run = 1'b0; clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({step, dut_vec} !== 26'd0) begin
      errors++;
      $display("FAIL reset_async: got step=%0d strobes=%h, want 0/0", step, dut_vec);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if ({step, dut_vec} !== 26'd0) begin
      errors++;
      $display("FAIL reset_idle: got step=%0d strobes=%h, want 0/0", step, dut_vec);
    end
  endtask

  task automatic test_ldi_zero_wait();
    begin_stream(op_for(K_LDI));
    build(K_LDI, op_for(K_LDI), 0, 0, 1'b0, 0);
    build(K_LDI, op_for(K_LDI), 0, 0, 1'b1, 3);
    end_stream();
    run_trace(q_exp.size());
    for (int i = 0; i < q_obs.size(); i++) begin
      checks++;
      if (q_obs[i] !== q_exp[i]) begin
        errors++;
        $display("FAIL ldi[%0d]: got step=%0d strobes=%h, want step=%0d strobes=%h", i,
                 q_obs[i][25:22], q_obs[i][21:0], q_exp[i][25:22], q_exp[i][21:0]);
      end
    end
    clear_q();
  endtask

  task automatic test_ld_wait_states();
    begin_stream(op_for(K_LD));
    build(K_LD, op_for(K_LD), 3, 3, 1'b1, 0);
    checks++;
    if (q_exp.size() - 1 != 14) begin
      errors++;
      $display("FAIL ld_length: got %0d cycles, want 14", q_exp.size() - 1);
    end
    end_stream();
    run_trace(q_exp.size());
    for (int i = 0; i < q_obs.size(); i++) begin
      checks++;
      if (q_obs[i] !== q_exp[i]) begin
        errors++;
        $display("FAIL ld_wait[%0d]: got step=%0d strobes=%h, want step=%0d strobes=%h", i,
                 q_obs[i][25:22], q_obs[i][21:0], q_exp[i][25:22], q_exp[i][21:0]);
      end
    end
    clear_q();
  endtask

  task automatic test_st();
    begin_stream(op_for(K_ST));
    build(K_ST, op_for(K_ST), 0, 2, 1'b1, 1);
    end_stream();
    run_trace(q_exp.size());
    for (int i = 0; i < q_obs.size(); i++) begin
      checks++;
      if (q_obs[i] !== q_exp[i]) begin
        errors++;
        $display("FAIL st[%0d]: got step=%0d strobes=%h, want step=%0d strobes=%h", i,
                 q_obs[i][25:22], q_obs[i][21:0], q_exp[i][25:22], q_exp[i][21:0]);
      end
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    int kind;
    logic [4:0] op;
    for (int r = 0; r < 4; r++) begin
      kind = int'($urandom_range(0, 3));
      begin_stream(op_for(kind));
      for (int k = 0; k < 6; k++) begin
        if (k > 0) kind = int'($urandom_range(0, 3));
        op = op_for(kind);
        build(kind, op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), k == 5,
              int'($urandom_range(0, 3)));
      end
      end_stream();
      run_trace(q_exp.size());
      for (int i = 0; i < q_obs.size(); i++) begin
        checks++;
        if (q_obs[i] !== q_exp[i]) begin
          errors++;
          $display("FAIL stream%0d[%0d]: got step=%0d strobes=%h, want step=%0d strobes=%h", r, i,
                   q_obs[i][25:22], q_obs[i][21:0], q_exp[i][25:22], q_exp[i][21:0]);
        end
      end
      clear_q();
    end
  endtask

  task automatic test_halt();
    begin_stream(op_for(K_HALT));
    build(K_HALT, op_for(K_HALT), int'($urandom_range(0, 2)), 0, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      push(4'd15, m(P_HALTED), rbit());
      q_run[q_run.size() - 1] = rbit();
    end
    run_trace(q_exp.size());
    for (int i = 0; i < q_obs.size(); i++) begin
      checks++;
      if (q_obs[i] !== q_exp[i]) begin
        errors++;
        $display("FAIL halt[%0d]: got step=%0d strobes=%h, want step=%0d strobes=%h", i,
                 q_obs[i][25:22], q_obs[i][21:0], q_exp[i][25:22], q_exp[i][21:0]);
      end
    end
    clear_q();
    apply_clr();
    checks++;
    if ({step, dut_vec} !== 26'd0) begin
      errors++;
      $display("FAIL halt_clr: got step=%0d strobes=%h, want 0/0", step, dut_vec);
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_async_reset();
    begin_stream(op_for(K_LD));
    build(K_LD, op_for(K_LD), 0, 3, 1'b0, 0);
    run_trace(8);
    checks++;
    if (q_obs[7] !== q_exp[7]) begin
      errors++;
      $display("FAIL pre_reset_t6: got step=%0d strobes=%h, want step=%0d strobes=%h",
               q_obs[7][25:22], q_obs[7][21:0], q_exp[7][25:22], q_exp[7][21:0]);
    end
    clear_q();
    #2 run = 1'b0; clr = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 22'd0) begin
      errors++;
      $display("FAIL midt6_strobes: got %h, want 0", dut_vec);
    end
    checks++;
    if (step !== 4'd0) begin
      errors++;
      $display("FAIL midt6_step: got %0d, want 0", step);
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_wait_timeout();
    int n_t1;
    begin_stream(op_for(K_LD));
    b_op = op_for(K_LD);
    push(4'd7, m(P_BUSY, P_PCOUT, P_MARIN, P_INCPC, P_ZIN), 1'b0);
`ifdef SEQ_TIMEOUT_EN
    n_t1 = TO_CYCLES;
`else
    n_t1 = 100;
`endif
    for (int i = 0; i < n_t1; i++)
      push(4'd8, m(P_BUSY, P_ZLOW, P_READ, P_MDRIN, (i == 0) ? P_PCIN : -1), 1'b0);
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 3; i++) push(4'd1, m(P_ERROR), rbit());
`endif
    run_trace(q_exp.size());
    for (int i = 0; i < q_obs.size(); i++) begin
      checks++;
      if (q_obs[i] !== q_exp[i]) begin
        errors++;
        $display("FAIL wait[%0d]: got step=%0d strobes=%h, want step=%0d strobes=%h", i,
                 q_obs[i][25:22], q_obs[i][21:0], q_exp[i][25:22], q_exp[i][21:0]);
      end
    end
    clear_q();
    apply_clr();
    checks++;
    if ({step, dut_vec} !== 26'd0) begin
      errors++;
      $display("FAIL wait_clr: got step=%0d strobes=%h, want 0/0", step, dut_vec);
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; run = 1'b0; mem_done = 1'b0; opcode = 5'd0;
    test_reset();
    test_ldi_zero_wait();
    test_ld_wait_states();
    test_st();
    test_back_to_back();
    test_halt();
    test_async_reset();
    test_wait_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
